// File: rtl/framebuffer_scan_reader_if.sv
// Frame-buffer read port plus VGA/DAC pins of the scan reader.
// The master side is the scan reader; the slave side is memory plus display.
`timescale 1ns/1ps
interface framebuffer_scan_reader_if;
  logic [18:0] mem_raddr;
  logic [2:0]  mem_rdata;
  logic        vga_clk;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        frame_start;

  modport master (
    output mem_raddr, vga_clk, vga_hsync, vga_vsync, vga_blank_n,
           vga_r, vga_g, vga_b, frame_start,
    input  mem_rdata
  );

  modport slave (
    input  mem_raddr, vga_clk, vga_hsync, vga_vsync, vga_blank_n,
           vga_r, vga_g, vga_b, frame_start,
    output mem_rdata
  );
endinterface

// File: rtl/framebuffer_scan_reader.sv
// Raster scan of the 3-bit index frame buffer: VGA timing, linear read address,
// index-to-RGB palette and a frame_start pulse, all aligned to memory read latency.
`timescale 1ns/1ps
module framebuffer_scan_reader #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int READ_LATENCY = 1
) (
  input logic clock,
  input logic reset,
  framebuffer_scan_reader_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [18:0]   addr, addr_nxt;
  logic          h_wrap, f_wrap;
  logic          raw_active, nxt_active, raw_hs, raw_vs;

  logic [READ_LATENCY-1:0] act_pipe, hs_pipe, vs_pipe;

  logic       blank_q, hsync_q, vsync_q, fs_q;
  logic [7:0] r_q, g_q, b_q;
  logic       act_out;
  logic [2:0] idx;

  always_comb begin
    h_wrap   = (h_cnt == H_LAST);
    f_wrap   = h_wrap && (v_cnt == V_LAST);
    h_nxt    = h_wrap ? '0 : h_cnt + HW'(1);
    v_nxt    = v_cnt;
    if (h_wrap) v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);

    raw_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    nxt_active = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    raw_hs     = (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
    raw_vs     = (v_cnt >= VS_ON) && (v_cnt < VS_OFF);

    // Advance only when the next pixel is visible, so the address parks on the
    // last pixel of a line through blanking and never runs past the final pixel.
    addr_nxt = addr;
    if (f_wrap)          addr_nxt = '0;
    else if (nxt_active) addr_nxt = addr + 19'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      addr  <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      addr  <= addr_nxt;
    end
  end

  // Sync flags are carried active-high so a cleared pipeline means "no pulse".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
    end else begin
      act_pipe[0] <= raw_active;
      hs_pipe[0]  <= raw_hs;
      vs_pipe[0]  <= raw_vs;
      for (int i = 1; i < READ_LATENCY; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
      end
    end
  end

  assign act_out = act_pipe[READ_LATENCY-1];
  assign idx     = bus.mem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blank_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      blank_q <= act_out;
      hsync_q <= ~hs_pipe[READ_LATENCY-1];
      vsync_q <= ~vs_pipe[READ_LATENCY-1];
      r_q     <= act_out ? {8{idx[2]}} : 8'h00;
      g_q     <= act_out ? {8{idx[1]}} : 8'h00;
      b_q     <= act_out ? {8{idx[0]}} : 8'h00;
      fs_q    <= f_wrap;
    end
  end

  assign bus.mem_raddr   = addr;
  assign bus.vga_clk     = ~clock;
  assign bus.vga_hsync   = hsync_q;
  assign bus.vga_vsync   = vsync_q;
  assign bus.vga_blank_n = blank_q;
  assign bus.vga_r       = r_q;
  assign bus.vga_g       = g_q;
  assign bus.vga_b       = b_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_framebuffer_scan_reader.sv
// Bench for framebuffer_scan_reader: default timing at latency 1 and 2, plus a
// shrunken geometry instance so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_framebuffer_scan_reader;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic force7 = 1'b0;
  logic [2:0] b_stage;

  always #20 clock = ~clock;

  framebuffer_scan_reader_if ia();
  framebuffer_scan_reader_if ib();
  framebuffer_scan_reader_if ic();

  framebuffer_scan_reader #(.READ_LATENCY(1)) dut_a (.clock(clock), .reset(reset), .bus(ia));
  framebuffer_scan_reader #(.READ_LATENCY(2)) dut_b (.clock(clock), .reset(reset), .bus(ib));
  framebuffer_scan_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .READ_LATENCY(1)
  ) dut_c (.clock(clock), .reset(reset), .bus(ic));

  // Memory models: index = low address bits, or constant 7 when forced.
  always @(posedge clock) begin
    ia.mem_rdata <= force7 ? 3'd7 : ia.mem_raddr[2:0];
    b_stage      <= ib.mem_raddr[2:0];
    ib.mem_rdata <= b_stage;
    ic.mem_rdata <= force7 ? 3'd7 : ic.mem_raddr[2:0];
  end

  typedef struct {
    int k; int raddr; int blank_a; int hs_a; int rgb_a; int blank_b; int hs_b; int rgb_b;
  } vec_t;
  vec_t vecs[21];

  int total = 0;
  int passed = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic advance_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    cyc = 0;
  endtask

  function automatic int rgb_of(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return int'({r, g, b});
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int prev_hs, nfall, fall1, fall2, w1, w2, fs_a_cnt, vs_a_low;
    int errs, blanked, p, ph, pv, pos, exp_act;
    int maxaddr, a119, a120, fs_first, fs_cnt1, fs_cnt_all, fs121, vs_cnt, vs_first;

    vecs = '{
      '{0,   0,   0, 1, 0,         0, 1, 0},
      '{1,   1,   0, 1, 0,         0, 1, 0},
      '{2,   2,   1, 1, 'h000000,  0, 1, 0},
      '{3,   3,   1, 1, 'h0000FF,  1, 1, 'h000000},
      '{4,   4,   1, 1, 'h00FF00,  1, 1, 'h0000FF},
      '{5,   5,   1, 1, 'h00FFFF,  1, 1, 'h00FF00},
      '{9,   9,   1, 1, 'hFFFFFF,  1, 1, 'hFFFF00},
      '{10,  10,  1, 1, 'h000000,  1, 1, 'hFFFFFF},
      '{641, 639, 1, 1, 'hFFFFFF,  1, 1, 'hFFFF00},
      '{642, 639, 0, 1, 0,         1, 1, 'hFFFFFF},
      '{643, 639, 0, 1, 0,         0, 1, 0},
      '{657, 639, 0, 1, 0,         0, 1, 0},
      '{658, 639, 0, 0, 0,         0, 1, 0},
      '{659, 639, 0, 0, 0,         0, 0, 0},
      '{753, 639, 0, 0, 0,         0, 0, 0},
      '{754, 639, 0, 1, 0,         0, 0, 0},
      '{755, 639, 0, 1, 0,         0, 1, 0},
      '{800, 640, 0, 1, 0,         0, 1, 0},
      '{802, 642, 1, 1, 0,         0, 1, 0},
      '{803, 643, 1, 1, 'h0000FF,  1, 1, 0},
      '{805, 645, 1, 1, 'h00FFFF,  1, 1, 'h00FF00}
    };

    #5 reset = 1'b1;
    @(negedge clock);
    chk("rst_raddr",  int'(ia.mem_raddr), 0);
    chk("rst_hsync",  int'(ia.vga_hsync), 1);
    chk("rst_vsync",  int'(ia.vga_vsync), 1);
    chk("rst_blank",  int'(ia.vga_blank_n), 0);
    chk("rst_rgb",    rgb_of(ia.vga_r, ia.vga_g, ia.vga_b), 0);
    chk("rst_fs",     int'(ia.frame_start), 0);
    chk("rst_hsync_b", int'(ib.vga_hsync), 1);
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;

    foreach (vecs[i]) begin
      advance_to(vecs[i].k);
      chk($sformatf("v%0d_k%0d_raddr", i, vecs[i].k), int'(ia.mem_raddr), vecs[i].raddr);
      chk($sformatf("v%0d_k%0d_blank_a", i, vecs[i].k), int'(ia.vga_blank_n), vecs[i].blank_a);
      chk($sformatf("v%0d_k%0d_hsync_a", i, vecs[i].k), int'(ia.vga_hsync), vecs[i].hs_a);
      chk($sformatf("v%0d_k%0d_rgb_a", i, vecs[i].k), rgb_of(ia.vga_r, ia.vga_g, ia.vga_b), vecs[i].rgb_a);
      chk($sformatf("v%0d_k%0d_blank_b", i, vecs[i].k), int'(ib.vga_blank_n), vecs[i].blank_b);
      chk($sformatf("v%0d_k%0d_hsync_b", i, vecs[i].k), int'(ib.vga_hsync), vecs[i].hs_b);
      chk($sformatf("v%0d_k%0d_rgb_b", i, vecs[i].k), rgb_of(ib.vga_r, ib.vga_g, ib.vga_b), vecs[i].rgb_b);
    end

    // hsync pulse position, width and period over lines 1 and 2
    prev_hs = int'(ia.vga_hsync);
    nfall = 0; fall1 = -1; fall2 = -1; w1 = 0; w2 = 0; fs_a_cnt = 0; vs_a_low = 0;
    while (cyc < 2400) begin
      step();
      if (ia.vga_hsync == 1'b0 && prev_hs == 1) begin
        nfall++;
        if (nfall == 1) fall1 = cyc;
        if (nfall == 2) fall2 = cyc;
      end
      if (ia.vga_hsync == 1'b0) begin
        if (nfall == 1) w1++;
        else if (nfall == 2) w2++;
      end
      if (ia.frame_start) fs_a_cnt++;
      if (!ia.vga_vsync) vs_a_low++;
      prev_hs = int'(ia.vga_hsync);
    end
    chk("hs_fall_line1", fall1, 1458);
    chk("hs_period", fall2 - fall1, 800);
    chk("hs_width_line1", w1, 96);
    chk("hs_width_line2", w2, 96);
    chk("fs_none_first_frame", fs_a_cnt, 0);
    chk("vs_high_early_lines", vs_a_low, 0);

    // asynchronous reset in the middle of line 1
    do_reset();
    advance_to(1100);
    chk("mid_pre_raddr", int'(ia.mem_raddr), 940);
    chk("mid_pre_blank", int'(ia.vga_blank_n), 1);
    chk("mid_pre_rgb", rgb_of(ia.vga_r, ia.vga_g, ia.vga_b), 'h00FF00);
    reset = 1'b1;
    #1;
    chk("mid_rst_raddr", int'(ia.mem_raddr), 0);
    chk("mid_rst_hsync", int'(ia.vga_hsync), 1);
    chk("mid_rst_vsync", int'(ia.vga_vsync), 1);
    chk("mid_rst_blank", int'(ia.vga_blank_n), 0);
    chk("mid_rst_rgb", rgb_of(ia.vga_r, ia.vga_g, ia.vga_b), 0);
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    chk("mid_rel_raddr0", int'(ia.mem_raddr), 0);
    step();
    chk("mid_rel_raddr1", int'(ia.mem_raddr), 1);
    chk("mid_rel_blank1", int'(ia.vga_blank_n), 0);
    step();
    chk("mid_rel_blank2", int'(ia.vga_blank_n), 1);
    chk("mid_rel_rgb2", rgb_of(ia.vga_r, ia.vga_g, ia.vga_b), 0);

    // memory stuck at index 7: blanking must mask it
    force7 = 1'b1;
    do_reset();
    errs = 0; blanked = 0;
    while (cyc < 1602) begin
      step();
      p = cyc - 2;
      if (p >= 0) begin
        exp_act = ((p % 800) < 640) ? 1 : 0;
        if (exp_act == 0) blanked++;
        if (int'(ia.vga_blank_n) != exp_act) errs++;
        if (rgb_of(ia.vga_r, ia.vga_g, ia.vga_b) != (exp_act != 0 ? 'hFFFFFF : 0)) errs++;
      end
    end
    chk("force7_errs", errs, 0);
    chk("force7_blanked", blanked, 320);

    // shrunken geometry: 15x8 total, 8x4 active, whole frames
    do_reset();
    errs = 0; maxaddr = 0; a119 = -1; a120 = -1; fs_first = -1; fs_cnt1 = 0;
    fs_cnt_all = 0; fs121 = -1; vs_cnt = 0; vs_first = -1;
    for (int n = 0; n <= 250; n++) begin
      if (n > 0) step();
      if (int'(ic.mem_raddr) > maxaddr) maxaddr = int'(ic.mem_raddr);
      if (cyc == 119) a119 = int'(ic.mem_raddr);
      if (cyc == 120) a120 = int'(ic.mem_raddr);
      if (cyc == 121) fs121 = int'(ic.frame_start);
      if (ic.frame_start) begin
        fs_cnt_all++;
        if (cyc < 240) fs_cnt1++;
        if (fs_first < 0) fs_first = cyc;
      end
      if (cyc < 120 && !ic.vga_vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = cyc;
      end
      p = cyc - 2;
      if (p >= 0) begin
        pos = p % 120;
        ph = pos % 15;
        pv = pos / 15;
        exp_act = (ph < 8 && pv < 4) ? 1 : 0;
        if (int'(ic.vga_blank_n) != exp_act) errs++;
        if (rgb_of(ic.vga_r, ic.vga_g, ic.vga_b) != (exp_act != 0 ? 'hFFFFFF : 0)) errs++;
      end
    end
    chk("small_max_addr", maxaddr, 31);
    chk("small_addr_last", a119, 31);
    chk("small_addr_wrap", a120, 0);
    chk("small_fs_first", fs_first, 120);
    chk("small_fs_once", fs_cnt1, 1);
    chk("small_fs_total", fs_cnt_all, 2);
    chk("small_fs_width", fs121, 0);
    chk("small_vs_width", vs_cnt, 30);
    chk("small_vs_first", vs_first, 77);
    chk("small_blank_errs", errs, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/framebuffer_scan_reader.md
Name: framebuffer_scan_reader

Overview:
- Read side of the 640x480 3-bit-index frame buffer that the index writer fills through its mem_waddr/mem_wdata/mem_wenable port.
- Generates VGA timing and walks the buffer in raster order on the memory read port.
- Maps each 3-bit index to 24-bit RGB and drives the DAC/VGA pins.
- Emits a frame_start pulse so upstream logic can align redraws to frame boundaries.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
READ_LATENCY, 1, clocks from mem_raddr valid to mem_rdata valid; legal values 1 or 2

Ports:
clock  in  1  pixel clock (25 MHz), one pixel per cycle
reset  in  1  asynchronous, active-high
mem_raddr  out  19  frame-buffer read address, y*H_ACTIVE + x
mem_rdata  in  3  palette index returned by memory
vga_clk  out  1  ~clock, forwarded to DAC
vga_hsync  out  1  active-low
vga_vsync  out  1  active-low
vga_blank_n  out  1  high during visible pixels
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
frame_start  out  1  one-cycle pulse at frame wrap

Behaviour:
- Totals: H_TOTAL = 800 and V_TOTAL = 525 at defaults. h_cnt counts 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Address counter (19 bits):
  - mem_raddr is the registered value of the counter.
  - Increments by 1 after each active-pixel cycle; holds during blanking.
  - Cleared to 0 on the edge where (h_cnt, v_cnt) wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - No multiplier is used.
  - Last active address is 307199. The counter never exceeds it.
- Sync generation:
  - Raw hsync = 0 when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - Raw vsync = 0 when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Pipeline:
  - Raw active, hsync and vsync are delayed READ_LATENCY stages to align with mem_rdata.
  - One output register stage follows, so all VGA outputs lag the counter state by READ_LATENCY+1 clocks.
  - Sync/blank/colour stay mutually aligned at every output cycle.
- Palette, registered in the output stage:
  - vga_r = {8{idx[2]}}, vga_g = {8{idx[1]}}, vga_b = {8{idx[0]}}.
  - Examples: 0 = black, 2 = green 00/FF/00, 7 = white.
- Blanking: when the delayed active flag is 0, vga_blank_n = 0 and RGB = 0 regardless of mem_rdata (X tolerated).
- frame_start:
  - Registered; high exactly one cycle, on the cycle after counters wrap to (0,0).
  - Not asserted for the first frame after reset release.
- Reset values, applied asynchronously and immediately, including mid-frame:
  - h_cnt = v_cnt = 0, mem_raddr = 0.
  - Pipeline flags cleared.
  - vga_hsync = 1, vga_vsync = 1, vga_blank_n = 0, vga_r/g/b = 0, frame_start = 0.
- After reset release, scan restarts at (0,0) with address 0 on the first rising edge.
- No dependency on writer activity: reads are continuous and the memory is assumed dual-ported. Tearing is acceptable; the writer may use frame_start to throttle.

Test Plan:
- Reset, release, memory model with READ_LATENCY=1 -> mem_raddr 0,1,…,639 over h 0..639, holds 639 for h 640..799, then 640 at (0,1); first vga_blank_n=1 two cycles after release.
- Run two lines -> vga_hsync low exactly 96 cycles starting 656 cycles (+2 pipeline) into each line; period 800 cycles; vsync low 1600 cycles starting line 490.
- Memory returns idx = addr[2:0] -> output pixels 0,2,7 of line 0 are 000000, 00FF00, FFFFFF; alignment holds with READ_LATENCY=2 (first visible pixel 3 cycles after release).
- mem_rdata forced to 7 during blanking -> RGB = 0 and vga_blank_n = 0 for all h ≥ 640 and all v ≥ 480.
- Run 420000 cycles -> last active address 307199, mem_raddr returns to 0, frame_start pulses exactly once and is one cycle wide.
- Assert reset at (h=300, v=100) mid-line -> same cycle: hsync=1, vsync=1, blank_n=0, RGB=0, mem_raddr=0; after release the scan restarts from (0,0).
